// File: rtl/matrix_capture_if.sv
// Bundles the display-driver tap (column selects, row lines) with the captured-frame
// outputs so the capture block and its user connect through one port.
interface matrix_capture_if;
    logic        C0, C1, C2, C3, C4;
    logic        L0, L1, L2, L3, L4, L5, L6;
    logic [34:0] frame;
    logic        frame_valid;
    logic        frame_changed;
    logic        seq_err;
    logic        timeout;
    logic [7:0]  frame_count;

    modport master (
        output C0, C1, C2, C3, C4,
        output L0, L1, L2, L3, L4, L5, L6,
        input  frame, frame_valid, frame_changed, seq_err, timeout, frame_count
    );

    modport slave (
        input  C0, C1, C2, C3, C4,
        input  L0, L1, L2, L3, L4, L5, L6,
        output frame, frame_valid, frame_changed, seq_err, timeout, frame_count
    );
endinterface

// File: rtl/matrix_capture.sv
// Snoops a 5x7 column-multiplexed LED matrix and rebuilds the displayed bitmap,
// publishing it only once a full, in-order column scan 0..4 has been captured.
module matrix_capture #(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 1048575
) (
    input  logic              clk50Mhz,
    input  logic              rst,
    matrix_capture_if.slave   bus
);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_WAIT_NEXT} state_t;

    state_t      state_q, state_d;
    logic [11:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]  col_q, col_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [34:0] shadow_q, shadow_d;
    logic [34:0] frame_q, frame_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_changed_q, frame_changed_d;
    logic        seq_err_q, seq_err_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  frame_count_q, frame_count_d;

    logic [4:0]  col_sel;
    logic [6:0]  rows_lit;
    logic        col_blank, col_legal, col_illegal, col_change;
    logic [2:0]  col_idx;
    logic [34:0] sampled;

    always_comb begin
        sync1_d = {bus.L6, bus.L5, bus.L4, bus.L3, bus.L2, bus.L1, bus.L0,
                   bus.C4, bus.C3, bus.C2, bus.C1, bus.C0};
        sync2_d = sync1_q;

        col_sel     = sync2_q[4:0];
        rows_lit    = ~sync2_q[11:5];
        col_blank   = (col_sel == 5'd0);
        col_legal   = $onehot(col_sel);
        col_illegal = !col_blank && !col_legal;
        case (col_sel)
            5'b00010: col_idx = 3'd1;
            5'b00100: col_idx = 3'd2;
            5'b01000: col_idx = 3'd3;
            5'b10000: col_idx = 3'd4;
            default:  col_idx = 3'd0;
        endcase

        // The synchronized code changes at the edge where stage 2 takes stage 1's value
        col_change = (sync1_q[4:0] != sync2_q[4:0]);
        if (col_change)
            to_cnt_d = '0;
        else if (to_cnt_q == TW'(TIMEOUT))
            to_cnt_d = to_cnt_q;
        else
            to_cnt_d = to_cnt_q + TW'(1);
        timeout_d = (to_cnt_d == TW'(TIMEOUT));
    end

    always_comb begin
        state_d         = state_q;
        col_d           = col_q;
        settle_cnt_d    = settle_cnt_q;
        shadow_d        = shadow_q;
        frame_d         = frame_q;
        frame_valid_d   = 1'b0;
        frame_changed_d = 1'b0;
        seq_err_d       = 1'b0;
        frame_count_d   = frame_count_q;
        sampled         = shadow_q;
        for (int c = 0; c < 5; c++)
            if (col_q == 3'(c))
                sampled[7*c +: 7] = rows_lit;

        if (state_q != S_IDLE && col_illegal) begin
            seq_err_d = 1'b1;
            shadow_d  = '0;
            state_d   = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A fresh scan starts from an empty shadow so unsampled columns read dark
                    if (col_legal && col_idx == 3'd0) begin
                        state_d      = S_SETTLE;
                        col_d        = 3'd0;
                        settle_cnt_d = '0;
                        shadow_d     = '0;
                    end
                end
                S_SETTLE: begin
                    if (col_legal && col_idx == col_q) begin
                        if (settle_cnt_q == SW'(SETTLE - 1))
                            state_d = S_SAMPLE;
                        else
                            settle_cnt_d = settle_cnt_q + SW'(1);
                    end else begin
                        state_d = (col_q == 3'd0) ? S_IDLE : S_WAIT_NEXT;
                    end
                end
                S_SAMPLE: begin
                    shadow_d = sampled;
                    if (col_q == 3'd4) begin
                        frame_d         = sampled;
                        frame_valid_d   = 1'b1;
                        frame_changed_d = (sampled != frame_q);
                        frame_count_d   = frame_count_q + 8'd1;
                        state_d         = S_IDLE;
                    end else begin
                        state_d = S_WAIT_NEXT;
                    end
                end
                S_WAIT_NEXT: begin
                    if (col_blank || (col_legal && col_idx == col_q)) begin
                        state_d = S_WAIT_NEXT;
                    end else if (col_legal && col_idx == col_q + 3'd1) begin
                        state_d      = S_SETTLE;
                        col_d        = col_idx;
                        settle_cnt_d = '0;
                    end else begin
                        seq_err_d = 1'b1;
                        shadow_d  = '0;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50Mhz) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            sync1_q         <= '0;
            sync2_q         <= '0;
            col_q           <= '0;
            settle_cnt_q    <= '0;
            to_cnt_q        <= '0;
            shadow_q        <= '0;
            frame_q         <= '0;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            seq_err_q       <= 1'b0;
            timeout_q       <= 1'b0;
            frame_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            col_q           <= col_d;
            settle_cnt_q    <= settle_cnt_d;
            to_cnt_q        <= to_cnt_d;
            shadow_q        <= shadow_d;
            frame_q         <= frame_d;
            frame_valid_q   <= frame_valid_d;
            frame_changed_q <= frame_changed_d;
            seq_err_q       <= seq_err_d;
            timeout_q       <= timeout_d;
            frame_count_q   <= frame_count_d;
        end
    end

    assign bus.frame         = frame_q;
    assign bus.frame_valid   = frame_valid_q;
    assign bus.frame_changed = frame_changed_q;
    assign bus.seq_err       = seq_err_q;
    assign bus.timeout       = timeout_q;
    assign bus.frame_count   = frame_count_q;
endmodule

// File: tb/tb_matrix_capture.sv
// Drives whole column scans of known bitmaps into matrix_capture and checks the
// captured frame, pulse counts, sequencing errors, timeout and reset behaviour.
module tb_matrix_capture;
    localparam int TB_TIMEOUT = 50;
    localparam logic [34:0] IMG_A    = {7'h7E, 7'h09, 7'h09, 7'h09, 7'h7E};
    localparam logic [34:0] IMG_ONES = 35'h7_FFFF_FFFF;
    localparam logic [34:0] IMG_CHK  = 35'h5_5555_5555;
    localparam logic [34:0] IMG_ZERO = 35'h0;
    localparam logic [34:0] ONES_NO2 = IMG_ONES & ~(35'h7F << 14);

    typedef struct {
        logic [34:0] img;
        logic [34:0] exp_frame;
        int          exp_valid;
        int          exp_changed;
        logic [7:0]  exp_count;
    } vec_t;

    logic clk;
    logic rst;
    matrix_capture_if bus();

    matrix_capture #(.SETTLE(16), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk50Mhz (clk),
        .rst      (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int fv_total = 0, fc_total = 0, se_total = 0;
    int fv_mark, fc_mark, se_mark;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1)   fv_total++;
        if (bus.frame_changed === 1'b1) fc_total++;
        if (bus.seq_err === 1'b1)       se_total++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic [4:0] c, input logic [6:0] lit);
        {bus.C4, bus.C3, bus.C2, bus.C1, bus.C0} = c;
        {bus.L6, bus.L5, bus.L4, bus.L3, bus.L2, bus.L1, bus.L0} = ~lit;
    endtask

    task automatic mark();
        fv_mark = fv_total;
        fc_mark = fc_total;
        se_mark = se_total;
    endtask

    task automatic check_output(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scan columns 0..4 showing img; one column may be held only short_len cycles
    task automatic apply_stimulus(input logic [34:0] img, input int short_col, input int short_len);
        for (int c = 0; c < 5; c++) begin
            logic [4:0] oh;
            oh = 5'd1 << c;
            set_inputs(oh, img[7*c +: 7]);
            tick((c == short_col) ? short_len : 40);
        end
        set_inputs(5'd0, 7'd0);
        tick(40);
    endtask

    task automatic check_deltas(input string tag, input int ev, input int ec, input int es);
        check_output({tag, " frame_valid pulses"},   35'(fv_total - fv_mark), 35'(ev));
        check_output({tag, " frame_changed pulses"}, 35'(fc_total - fc_mark), 35'(ec));
        check_output({tag, " seq_err pulses"},       35'(se_total - se_mark), 35'(es));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{IMG_A,    IMG_A,    1, 1, 8'd1};
        vecs[1] = '{IMG_A,    IMG_A,    1, 0, 8'd2};
        vecs[2] = '{IMG_ONES, IMG_ONES, 1, 1, 8'd3};
        vecs[3] = '{IMG_ZERO, IMG_ZERO, 1, 1, 8'd4};
        vecs[4] = '{IMG_ZERO, IMG_ZERO, 1, 0, 8'd5};
        vecs[5] = '{IMG_CHK,  IMG_CHK,  1, 1, 8'd6};

        rst = 1'b0;
        set_inputs(5'd0, 7'd0);
        tick(5);
        check_output("reset frame",         bus.frame, 35'd0);
        check_output("reset frame_valid",   35'(bus.frame_valid), 35'd0);
        check_output("reset frame_changed", 35'(bus.frame_changed), 35'd0);
        check_output("reset seq_err",       35'(bus.seq_err), 35'd0);
        check_output("reset timeout",       35'(bus.timeout), 35'd0);
        check_output("reset frame_count",   35'(bus.frame_count), 35'd0);
        rst = 1'b1;
        tick(3);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            mark();
            apply_stimulus(vecs[i].img, -1, 0);
            check_output({tag, " frame"}, bus.frame, vecs[i].exp_frame);
            check_output({tag, " frame_count"}, 35'(bus.frame_count), 35'(vecs[i].exp_count));
            check_deltas(tag, vecs[i].exp_valid, vecs[i].exp_changed, 0);
        end

        // Out-of-order scan 0,1,3
        mark();
        set_inputs(5'b00001, 7'h11); tick(40);
        set_inputs(5'b00010, 7'h22); tick(40);
        set_inputs(5'b01000, 7'h33); tick(40);
        set_inputs(5'd0, 7'd0);      tick(40);
        check_deltas("skip", 0, 0, 1);
        check_output("skip frame", bus.frame, IMG_CHK);
        check_output("skip frame_count", 35'(bus.frame_count), 35'd6);

        // Two columns selected at once mid-capture, then a clean scan
        mark();
        set_inputs(5'b00001, 7'h11); tick(40);
        set_inputs(5'b00010, 7'h22); tick(40);
        set_inputs(5'b00110, 7'h22); tick(10);
        set_inputs(5'd0, 7'd0);      tick(10);
        check_deltas("illegal", 0, 0, 1);
        check_output("illegal frame", bus.frame, IMG_CHK);
        mark();
        apply_stimulus(IMG_A, -1, 0);
        check_deltas("recover", 1, 1, 0);
        check_output("recover frame", bus.frame, IMG_A);
        check_output("recover frame_count", 35'(bus.frame_count), 35'd7);

        // Column 2 held too briefly: its slice stays dark
        mark();
        apply_stimulus(IMG_ONES, 2, 10);
        check_deltas("short col2", 1, 1, 0);
        check_output("short col2 frame", bus.frame, ONES_NO2);
        check_output("short col2 frame_count", 35'(bus.frame_count), 35'd8);

        // Column 4 glitch: no commit
        mark();
        apply_stimulus(IMG_A, 4, 10);
        check_deltas("glitch col4", 0, 0, 0);
        check_output("glitch col4 frame", bus.frame, ONES_NO2);
        check_output("glitch col4 frame_count", 35'(bus.frame_count), 35'd8);

        // Frozen inputs raise timeout; a column change drops it
        tick(TB_TIMEOUT + 3);
        check_output("timeout set", 35'(bus.timeout), 35'd1);
        set_inputs(5'b00100, 7'h00);
        tick(3);
        check_output("timeout cleared", 35'(bus.timeout), 35'd0);
        tick(5);

        // Reset during column 2 discards the partial capture
        mark();
        set_inputs(5'b00001, 7'h7F); tick(40);
        set_inputs(5'b00010, 7'h7F); tick(40);
        set_inputs(5'b00100, 7'h7F); tick(20);
        rst = 1'b0;
        tick(2);
        check_output("midreset frame",         bus.frame, 35'd0);
        check_output("midreset frame_valid",   35'(bus.frame_valid), 35'd0);
        check_output("midreset frame_changed", 35'(bus.frame_changed), 35'd0);
        check_output("midreset seq_err",       35'(bus.seq_err), 35'd0);
        check_output("midreset timeout",       35'(bus.timeout), 35'd0);
        check_output("midreset frame_count",   35'(bus.frame_count), 35'd0);
        rst = 1'b1;
        tick(20);
        set_inputs(5'd0, 7'd0);
        tick(40);
        check_deltas("midreset", 0, 0, 0);
        check_output("midreset after frame", bus.frame, 35'd0);

        // First commit after reset of a blank image: no frame_changed
        mark();
        apply_stimulus(IMG_ZERO, -1, 0);
        check_deltas("first blank", 1, 0, 0);
        check_output("first blank frame", bus.frame, 35'd0);
        check_output("first blank frame_count", 35'(bus.frame_count), 35'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
